systolic_array: RTL and testbench
=================================

SYSTOLIC_ARRAY -- requirements
Module: systolic_array

Interface
REQ-001 SHALL have parameter MAX_STRING_LENGTH, default from shared package, meaning read/haplotype buffer depth.
REQ-002 SHALL have parameter NUM_PROCS, default from shared package, meaning PE count (rows per strip).
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low.
REQ-005 base_reads  in  READS  {valid, reference: STRING, exp[NUM_PROCS]: STRING}.
REQ-006 prior_reads  in  PRIORS  {valid, match[NUM_PROCS], neq[NUM_PROCS]: 64-bit binary64}.
REQ-007 string_length  in  clog2(MAX_STRING_LENGTH)  L, common length of both strings.
REQ-008 tp  in  transition_probs  binary64 a_mm, a_im, a_dm, a_mi, a_ii, a_md, a_dd; static during a run.
REQ-009 complete  out  1  all computation finished, final_val valid.
REQ-010 read_index_x / read_x_valid  out  clog2(MAX)/1  request reference base j.
REQ-011 read_index_y / read_y_valid  out  clog2(MAX)/1  request exp bases and priors rows y..y+NUM_PROCS-1.
REQ-012 final_val  out  64  binary64 forward likelihood.

Function
REQ-013 SHALL compute the Pair-HMM forward recurrence, row i = exp index, column j = reference index, 0..L-1.
REQ-014 prior(i,j) SHALL be match[i] if exp[i]==reference[j], else neq[i].
REQ-015 M(i,j) SHALL = prior*(a_mm*M(i-1,j-1)+a_im*I(i-1,j-1)+a_dm*D(i-1,j-1)).
REQ-016 I(i,j) SHALL = a_mi*M(i-1,j)+a_ii*I(i-1,j); D(i,j) SHALL = a_md*M(i,j-1)+a_dd*D(i,j-1).
REQ-017 Boundaries: row -1 SHALL have M=I=0, D=1/L for j>=-1; column -1 (rows>=0) SHALL have M=I=D=0.
REQ-018 final_val SHALL = sum over j of M(L-1,j)+I(L-1,j).
REQ-019 Arithmetic SHALL be IEEE-754 binary64; this revision is a behavioural model (bits<->real conversion), not synthesis-targeted.
REQ-020 Rows SHALL be processed in strips of NUM_PROCS; strip s uses PE k for row s*NUM_PROCS+k.
REQ-021 Strip start: read_y_valid SHALL pulse 1 cycle with read_index_y=s*NUM_PROCS; exp/priors SHALL be sampled the following cycle (1-cycle latency, source holds them).
REQ-022 Per column: read_x_valid SHALL pulse with read_index_x=j, j=0..L-1 ascending, one per cycle; base_reads.reference SHALL be sampled next cycle into PE0 and shifted one PE per cycle (wavefront).
REQ-023 Bottom-row M/I/D of each strip SHALL be stored in a MAX_STRING_LENGTH-entry row buffer feeding PE0 of the next strip.
REQ-024 PEs for rows >= L SHALL be masked; final row taken from PE (L-1) mod NUM_PROCS.
REQ-025 FSM states: IDLE -> LOAD_Y -> STREAM_X -> DRAIN -> (next strip LOAD_Y | DONE); DONE holds until reset.
REQ-026 Computation SHALL start automatically on the first clock after reset deasserts.
REQ-027 complete SHALL rise once, after the last strip drains, with final_val stable; both held until reset.
REQ-028 L=0 SHALL go directly to DONE, final_val=0, no read requests.
REQ-029 Requests SHALL never index >= L.

Reset
REQ-030 Reset asserted SHALL immediately clear complete, read_x_valid, read_y_valid, indices, final_val to 0, row buffer and PE registers to 0, FSM to IDLE; mid-run assertion aborts the run.

Structure
REQ-031 STRING enum (A,C,G,T,DASH), READS, PRIORS, transition_probs, MAX_STRING_LENGTH, NUM_PROCS SHALL live in the shared package.
REQ-032 One sub-module sa_pe (one cell: M/I/D update, shift registers) SHALL be instantiated NUM_PROCS times.

Verification
REQ-033 L=1, ref=A, exp=A, match=0.999, neq=0.001, qi=qd=0.001, qg=0.1 -> final_val=0.8991.
REQ-034 Same but exp=C -> final_val=9.0e-4.
REQ-035 L=NUM_PROCS+1 random strings/qualities -> matches software golden within 1e-9 relative; read_index_y sequence 0, NUM_PROCS.
REQ-036 L=0 -> complete within 2 cycles, final_val=0, no valid pulses.
REQ-037 Reset asserted mid-STREAM_X -> all outputs 0 same cycle; rerun gives identical final_val.
REQ-038 Any L -> read_index_x steps 0..L-1 contiguously per strip, one pulse per cycle.

Source files
------------

// File: rtl/systolic_array_pkg.sv
// Shared types and sizing for the Pair-HMM forward systolic array.
// Arithmetic is carried as binary64 bit patterns and evaluated through real.
package systolic_array_pkg;

  localparam int MAX_STRING_LENGTH = 16;
  localparam int NUM_PROCS         = 4;

  typedef enum logic [2:0] {A, C, G, T, DASH} STRING;

  typedef struct packed {
    logic                    valid;
    STRING                   reference;
    STRING [NUM_PROCS-1:0]   exp;
  } READS;

  typedef struct packed {
    logic                         valid;
    logic [NUM_PROCS-1:0][63:0]   match;
    logic [NUM_PROCS-1:0][63:0]   neq;
  } PRIORS;

  typedef struct packed {
    logic [63:0] a_mm, a_im, a_dm, a_mi, a_ii, a_md, a_dd;
  } transition_probs;

  typedef struct packed {
    logic [63:0] m, i, d;
  } cell_t;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_Y, S_STREAM_X, S_DRAIN, S_DONE} state_t;

  function automatic real b2r(input logic [63:0] b);
    return $bitstoreal(b);
  endfunction

  // Row -1 deletion start value 1/L; L=0 never reaches the array.
  function automatic logic [63:0] inv_len(input int l);
    if (l == 0) return '0;
    return $realtobits(1.0 / $itor(l));
  endfunction

endpackage

// File: rtl/systolic_array_pe.sv
// One processing element: computes M/I/D for its row, one column per valid
// input, and forwards base, column index and its current/previous cells.
module sa_pe
  import systolic_array_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_vld,
  input  logic [IDX_W-1:0] i_col,
  input  STRING            i_base,
  input  cell_t            i_up,
  input  cell_t            i_dg,
  input  STRING            i_exp,
  input  logic [63:0]      i_match,
  input  logic [63:0]      i_neq,
  input  transition_probs  i_tp,
  input  logic             i_mask,
  output logic             o_vld,
  output logic [IDX_W-1:0] o_col,
  output STRING            o_base,
  output cell_t            o_cur,
  output cell_t            o_prev
);

  logic             r_vld;
  logic [IDX_W-1:0] r_col;
  STRING            r_base;
  cell_t            r_cur, r_prev;

  real   w_pr, w_lm, w_ld;
  cell_t w_nxt;

  // Left neighbour is column -1 (all zero) on the first column of a strip.
  always_comb begin
    w_pr    = b2r((i_base == i_exp) ? i_match : i_neq);
    w_lm    = (i_col == '0) ? 0.0 : b2r(r_cur.m);
    w_ld    = (i_col == '0) ? 0.0 : b2r(r_cur.d);
    w_nxt   = '0;
    w_nxt.m = $realtobits(w_pr * (b2r(i_tp.a_mm) * b2r(i_dg.m) +
                                  b2r(i_tp.a_im) * b2r(i_dg.i) +
                                  b2r(i_tp.a_dm) * b2r(i_dg.d)));
    w_nxt.i = $realtobits(b2r(i_tp.a_mi) * b2r(i_up.m) + b2r(i_tp.a_ii) * b2r(i_up.i));
    w_nxt.d = $realtobits(b2r(i_tp.a_md) * w_lm + b2r(i_tp.a_dd) * w_ld);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld  <= 1'b0;
      r_col  <= '0;
      r_base <= A;
      r_cur  <= '0;
      r_prev <= '0;
    end else begin
      r_vld <= i_vld;
      if (i_vld) begin
        r_col  <= i_col;
        r_base <= i_base;
        r_prev <= (i_col == '0) ? '0 : r_cur;
        r_cur  <= i_mask ? '0 : w_nxt;
      end
    end
  end

  assign o_vld  = r_vld;
  assign o_col  = r_col;
  assign o_base = r_base;
  assign o_cur  = r_cur;
  assign o_prev = r_prev;

endmodule

// File: rtl/systolic_array.sv
// Pair-HMM forward systolic array: rows processed in strips of NUM_PROCS PEs,
// reference bases streamed as a wavefront, strip boundary held in a row buffer.
module systolic_array
  import systolic_array_pkg::*;
#(
  parameter int MAX_STRING_LENGTH = systolic_array_pkg::MAX_STRING_LENGTH,
  parameter int NUM_PROCS         = systolic_array_pkg::NUM_PROCS
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  READS                                 base_reads,
  input  PRIORS                                prior_reads,
  input  logic [$clog2(MAX_STRING_LENGTH)-1:0] string_length,
  input  transition_probs                      tp,
  output logic                                 complete,
  output logic [$clog2(MAX_STRING_LENGTH)-1:0] read_index_x,
  output logic                                 read_x_valid,
  output logic [$clog2(MAX_STRING_LENGTH)-1:0] read_index_y,
  output logic                                 read_y_valid,
  output logic [63:0]                          final_val
);

  localparam int LW = $clog2(MAX_STRING_LENGTH);
  localparam int PW = (NUM_PROCS > 1) ? $clog2(NUM_PROCS) : 1;

  state_t        r_state;
  logic          r_complete;
  logic [63:0]   r_final, r_acc;
  logic          r_x_valid, r_x_vld_d, r_y_valid, r_y_vld_d;
  logic [LW-1:0] r_x_idx, r_x_idx_d, r_y_idx;
  STRING         r_exp    [NUM_PROCS];
  logic [63:0]   r_match  [NUM_PROCS];
  logic [63:0]   r_neq    [NUM_PROCS];
  cell_t         r_rowbuf [MAX_STRING_LENGTH];

  logic [NUM_PROCS-1:0] w_vld, w_mask, w_in_vld;
  logic [LW-1:0]        w_col    [NUM_PROCS];
  logic [LW-1:0]        w_in_col [NUM_PROCS];
  STRING                w_base   [NUM_PROCS];
  STRING                w_in_base[NUM_PROCS];
  cell_t                w_cur    [NUM_PROCS];
  cell_t                w_prev   [NUM_PROCS];
  cell_t                w_in_up  [NUM_PROCS];
  cell_t                w_in_dg  [NUM_PROCS];
  cell_t                w_up0, w_dg0;
  logic [63:0]          w_dinit;
  logic                 w_last;
  logic [LW-1:0]        w_fin_full;
  logic [PW-1:0]        w_fin;
  logic                 w_unused;

  assign w_dinit    = inv_len(int'(string_length));
  assign w_last     = (int'(r_y_idx) + NUM_PROCS) >= int'(string_length);
  assign w_fin_full = string_length - r_y_idx - LW'(1);
  assign w_fin      = w_fin_full[PW-1:0];
  assign w_unused   = ^{base_reads.valid, prior_reads.valid,
                        w_prev[NUM_PROCS-1], w_base[NUM_PROCS-1]};

  // PE0 neighbours: row -1 boundary on the first strip, else the row buffer.
  always_comb begin
    w_up0 = '0;
    w_dg0 = '0;
    if (r_y_idx == '0) begin
      w_up0.d = w_dinit;
      w_dg0.d = w_dinit;
    end else begin
      w_up0 = r_rowbuf[r_x_idx_d];
      if (r_x_idx_d != '0) w_dg0 = r_rowbuf[r_x_idx_d - LW'(1)];
    end
  end

  for (genvar k = 0; k < NUM_PROCS; k++) begin : g_pe
    if (k == 0) begin : g_head
      assign w_in_vld[k]  = r_x_vld_d;
      assign w_in_col[k]  = r_x_idx_d;
      assign w_in_base[k] = base_reads.reference;
      assign w_in_up[k]   = w_up0;
      assign w_in_dg[k]   = w_dg0;
    end else begin : g_link
      assign w_in_vld[k]  = w_vld[k-1];
      assign w_in_col[k]  = w_col[k-1];
      assign w_in_base[k] = w_base[k-1];
      assign w_in_up[k]   = w_cur[k-1];
      assign w_in_dg[k]   = w_prev[k-1];
    end
    assign w_mask[k] = (int'(r_y_idx) + k) >= int'(string_length);

    sa_pe #(.IDX_W(LW)) u_pe (
      .clk    (clk),
      .reset  (reset),
      .i_vld  (w_in_vld[k]),
      .i_col  (w_in_col[k]),
      .i_base (w_in_base[k]),
      .i_up   (w_in_up[k]),
      .i_dg   (w_in_dg[k]),
      .i_exp  (r_exp[k]),
      .i_match(r_match[k]),
      .i_neq  (r_neq[k]),
      .i_tp   (tp),
      .i_mask (w_mask[k]),
      .o_vld  (w_vld[k]),
      .o_col  (w_col[k]),
      .o_base (w_base[k]),
      .o_cur  (w_cur[k]),
      .o_prev (w_prev[k])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_complete <= 1'b0;
      r_final    <= '0;
      r_acc      <= '0;
      r_x_valid  <= 1'b0;
      r_x_vld_d  <= 1'b0;
      r_y_valid  <= 1'b0;
      r_y_vld_d  <= 1'b0;
      r_x_idx    <= '0;
      r_x_idx_d  <= '0;
      r_y_idx    <= '0;
      for (int k = 0; k < NUM_PROCS; k++) begin
        r_exp[k]   <= A;
        r_match[k] <= '0;
        r_neq[k]   <= '0;
      end
      for (int e = 0; e < MAX_STRING_LENGTH; e++) r_rowbuf[e] <= '0;
    end else begin
      r_x_vld_d <= r_x_valid;
      r_x_idx_d <= r_x_idx;
      r_y_vld_d <= r_y_valid;
      if (r_y_vld_d) begin
        for (int k = 0; k < NUM_PROCS; k++) begin
          r_exp[k]   <= base_reads.exp[k];
          r_match[k] <= prior_reads.match[k];
          r_neq[k]   <= prior_reads.neq[k];
        end
      end
      if (w_vld[NUM_PROCS-1]) r_rowbuf[w_col[NUM_PROCS-1]] <= w_cur[NUM_PROCS-1];
      if (w_last && w_vld[w_fin])
        r_acc <= $realtobits(b2r(r_acc) + (b2r(w_cur[w_fin].m) + b2r(w_cur[w_fin].i)));

      case (r_state)
        S_IDLE: begin
          r_acc <= '0;
          if (string_length == '0) begin
            r_state    <= S_DONE;
            r_complete <= 1'b1;
            r_final    <= '0;
          end else begin
            r_state   <= S_LOAD_Y;
            r_y_valid <= 1'b1;
            r_y_idx   <= '0;
          end
        end
        S_LOAD_Y: begin
          r_y_valid <= 1'b0;
          if (r_y_vld_d) begin
            r_state   <= S_STREAM_X;
            r_x_valid <= 1'b1;
            r_x_idx   <= '0;
          end
        end
        S_STREAM_X: begin
          if (r_x_idx == string_length - LW'(1)) begin
            r_x_valid <= 1'b0;
            r_state   <= S_DRAIN;
          end else begin
            r_x_idx <= r_x_idx + LW'(1);
          end
        end
        S_DRAIN: begin
          // Wait until the wavefront has left every PE, so the row buffer
          // and accumulator hold the finished strip.
          if (!r_x_vld_d && (w_vld == '0)) begin
            if (w_last) begin
              r_state    <= S_DONE;
              r_complete <= 1'b1;
              r_final    <= r_acc;
            end else begin
              r_state   <= S_LOAD_Y;
              r_y_valid <= 1'b1;
              r_y_idx   <= r_y_idx + LW'(NUM_PROCS);
            end
          end
        end
        S_DONE:  r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign complete     = r_complete;
  assign final_val    = r_final;
  assign read_x_valid = r_x_valid;
  assign read_index_x = r_x_idx;
  assign read_y_valid = r_y_valid;
  assign read_index_y = r_y_idx;

endmodule

// File: tb/tb_systolic_array.sv
// Scoreboard bench: runs push expected likelihood / request counts, a monitor
// pops them when complete rises and checks request index sequences on the fly.
module tb_systolic_array;
  import systolic_array_pkg::*;

  localparam int MAXL = 16;
  localparam int NP   = 4;
  localparam int LW   = 4;
  localparam int BUDGET = 2000;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  READS            base_reads;
  PRIORS           prior_reads;
  logic [LW-1:0]   string_length;
  transition_probs tp;
  logic            complete, read_x_valid, read_y_valid;
  logic [LW-1:0]   read_index_x, read_index_y;
  logic [63:0]     final_val;

  systolic_array #(.MAX_STRING_LENGTH(MAXL), .NUM_PROCS(NP)) dut (
    .clk          (clk),
    .reset        (reset),
    .base_reads   (base_reads),
    .prior_reads  (prior_reads),
    .string_length(string_length),
    .tp           (tp),
    .complete     (complete),
    .read_index_x (read_index_x),
    .read_x_valid (read_x_valid),
    .read_index_y (read_index_y),
    .read_y_valid (read_y_valid),
    .final_val    (final_val)
  );

  always #5 clk = ~clk;

  typedef struct { real fv; int nx; } exp_t;
  exp_t sb[$];
  int   yq[$];
  int   n_chk = 0, n_err = 0;
  bit   mon_off = 1'b0;

  STRING ref_s[MAXL], exp_s[MAXL];
  real   match_r[MAXL], neq_r[MAXL];
  real   amm, aim, adm, ami, aii, amd, add_p;

  task automatic chk_int(input string nm, input longint got, input longint want);
    n_chk++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  task automatic chk_real(input string nm, input logic [63:0] got_b, input real want);
    real got, d, lim;
    got = $bitstoreal(got_b);
    d   = got - want;
    if (d < 0.0) d = -d;
    lim = (want < 0.0 ? -want : want) * 1.0e-9;
    n_chk++;
    if ((want == 0.0) ? (got != 0.0) : (d > lim)) begin
      n_err++;
      $display("FAIL %s: got %g expected %g", nm, got, want);
    end
  endtask

  // Source: answers a request seen in one cycle during the next cycle.
  bit px_v, py_v;
  int px_i, py_i;
  always @(negedge clk) begin
    if (!reset) begin
      base_reads.valid     = 1'b1;
      base_reads.reference = A;
      prior_reads.valid    = 1'b1;
      for (int k = 0; k < NP; k++) begin
        base_reads.exp[k]    = DASH;
        prior_reads.match[k] = '0;
        prior_reads.neq[k]   = '0;
      end
    end else begin
      if (px_v) base_reads.reference = ref_s[px_i];
      if (py_v) begin
        for (int k = 0; k < NP; k++) begin
          if (py_i + k < int'(string_length)) begin
            base_reads.exp[k]    = exp_s[py_i + k];
            prior_reads.match[k] = $realtobits(match_r[py_i + k]);
            prior_reads.neq[k]   = $realtobits(neq_r[py_i + k]);
          end else begin
            base_reads.exp[k]    = DASH;
            prior_reads.match[k] = '0;
            prior_reads.neq[k]   = '0;
          end
        end
      end
    end
    px_v = read_x_valid;
    px_i = int'(read_index_x);
    py_v = read_y_valid;
    py_i = int'(read_index_y);
  end

  // Monitor
  int mx_exp, mx_cnt;
  bit m_seen, m_prev_xv;
  always @(negedge clk) begin
    if (!reset) begin
      mx_exp = 0; mx_cnt = 0; m_seen = 1'b0; m_prev_xv = 1'b0;
    end else if (!mon_off) begin
      if (read_y_valid) begin
        if (yq.size() == 0) chk_int("y_unexpected", 1, 0);
        else chk_int("y_index", read_index_y, yq.pop_front());
        mx_exp = 0;
      end
      if (read_x_valid) begin
        chk_int("x_index", read_index_x, mx_exp);
        if (mx_exp > 0) chk_int("x_contiguous", m_prev_xv, 1);
        mx_exp++;
        mx_cnt++;
      end
      m_prev_xv = read_x_valid;
      if (complete && !m_seen) begin
        exp_t e;
        m_seen = 1'b1;
        if (sb.size() == 0) chk_int("sb_unexpected_complete", 1, 0);
        else begin
          e = sb.pop_front();
          chk_real("final_val", final_val, e.fv);
          chk_int("x_pulse_count", mx_cnt, e.nx);
        end
      end
    end
  end

  function automatic STRING nb(input int v);
    case (v % 4)
      0:       return A;
      1:       return C;
      2:       return G;
      default: return T;
    endcase
  endfunction

  task automatic set_vec(input int seed);
    real e;
    for (int i = 0; i < MAXL; i++) begin
      ref_s[i]   = nb(i * 7 + seed);
      exp_s[i]   = ((i + seed) % 3 == 0) ? nb(i * 7 + seed + 1) : ref_s[i];
      e          = 0.001 * (1 + ((i * 5 + seed) % 9));
      match_r[i] = 1.0 - e;
      neq_r[i]   = e / 3.0;
    end
  endtask

  function automatic real golden(input int len);
    real m[MAXL+1][MAXL+1], ii[MAXL+1][MAXL+1], dd[MAXL+1][MAXL+1];
    real pr, s;
    for (int j = 0; j <= len; j++) begin
      m[0][j] = 0.0; ii[0][j] = 0.0; dd[0][j] = 1.0 / len;
    end
    for (int i = 1; i <= len; i++) begin
      m[i][0] = 0.0; ii[i][0] = 0.0; dd[i][0] = 0.0;
    end
    for (int i = 1; i <= len; i++)
      for (int j = 1; j <= len; j++) begin
        pr = (exp_s[i-1] == ref_s[j-1]) ? match_r[i-1] : neq_r[i-1];
        m[i][j]  = pr * (amm * m[i-1][j-1] + aim * ii[i-1][j-1] + adm * dd[i-1][j-1]);
        ii[i][j] = ami * m[i-1][j] + aii * ii[i-1][j];
        dd[i][j] = amd * m[i][j-1] + add_p * dd[i][j-1];
      end
    s = 0.0;
    for (int j = 1; j <= len; j++) s = s + (m[len][j] + ii[len][j]);
    return s;
  endfunction

  task automatic do_run(input int len, input real expv, output int cyc);
    exp_t e;
    int strips;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    string_length = LW'(len);
    strips = (len + NP - 1) / NP;
    e.fv = expv;
    e.nx = strips * len;
    sb.push_back(e);
    for (int s = 0; s < strips; s++) yq.push_back(s * NP);
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    while (!complete && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    if (!complete) chk_int("complete_timeout", 0, 1);
    repeat (3) @(negedge clk);
    chk_int("complete_held", complete, 1);
  endtask

  initial begin
    int cyc;
    amm = 0.998; aim = 0.9; adm = 0.9; ami = 0.001; aii = 0.1; amd = 0.001; add_p = 0.1;
    tp.a_mm = $realtobits(amm); tp.a_im = $realtobits(aim); tp.a_dm = $realtobits(adm);
    tp.a_mi = $realtobits(ami); tp.a_ii = $realtobits(aii);
    tp.a_md = $realtobits(amd); tp.a_dd = $realtobits(add_p);
    string_length = '0;
    set_vec(0);

    repeat (2) @(negedge clk);
    chk_int("rst_complete", complete, 0);
    chk_int("rst_x_valid", read_x_valid, 0);
    chk_int("rst_y_valid", read_y_valid, 0);
    chk_int("rst_x_index", read_index_x, 0);
    chk_int("rst_y_index", read_index_y, 0);
    chk_int("rst_final_val", final_val, 0);

    // Hand-computed single-cell cases: 0.999*0.9 and 0.001*0.9.
    ref_s[0] = A; exp_s[0] = A; match_r[0] = 0.999; neq_r[0] = 0.001;
    do_run(1, 0.8991, cyc);
    exp_s[0] = C;
    do_run(1, 9.0e-4, cyc);

    do_run(0, 0.0, cyc);
    chk_int("l0_complete_latency_ok", (cyc <= 2) ? 1 : 0, 1);

    set_vec(3);  do_run(NP + 1, golden(NP + 1), cyc);
    set_vec(5);  do_run(NP, golden(NP), cyc);
    set_vec(8);  do_run(11, golden(11), cyc);
    set_vec(11); do_run(15, golden(15), cyc);

    // Abort mid-stream, then rerun the same vector from scratch.
    set_vec(3);
    reset = 1'b0;
    mon_off = 1'b1;
    repeat (2) @(negedge clk);
    string_length = LW'(NP + 1);
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    while (!read_x_valid && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    chk_int("abort_reached_stream", read_x_valid, 1);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk_int("abort_complete", complete, 0);
    chk_int("abort_x_valid", read_x_valid, 0);
    chk_int("abort_y_valid", read_y_valid, 0);
    chk_int("abort_x_index", read_index_x, 0);
    chk_int("abort_y_index", read_index_y, 0);
    chk_int("abort_final_val", final_val, 0);
    @(negedge clk);
    mon_off = 1'b0;
    do_run(NP + 1, golden(NP + 1), cyc);

    chk_int("sb_drained", sb.size(), 0);
    chk_int("yq_drained", yq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
